// File: rtl/sci_link_peer.sv
// SCI link partner: 8-bit async serial transmitter and receiver with optional parity
// and one or two stop bits. TX and RX run independently off the shared CE bit-rate tick.
module sci_link_peer #(
    parameter int BIT_CYCLES = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE,
    input  logic       PE,
    input  logic       OE,
    input  logic       STOP,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       SER_TX,
    input  logic       SER_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_PERR,
    output logic       RX_FERR
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_pe_q, tx_pe_d, tx_oe_q, tx_oe_d, tx_stop_q, tx_stop_d;
    logic            ser_tx_q, ser_tx_d;

    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [1:0]      sync_q, sync_d;
    logic            rx_prev_q, rx_prev_d;
    logic            rx_pe_q, rx_pe_d, rx_oe_q, rx_oe_d, rx_par_q, rx_par_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_valid_q, rx_valid_d;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            tx_pe_q    <= 1'b0;
            tx_oe_q    <= 1'b0;
            tx_stop_q  <= 1'b0;
            ser_tx_q   <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_pe_q    <= 1'b0;
            rx_oe_q    <= 1'b0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            tx_pe_q    <= tx_pe_d;
            tx_oe_q    <= tx_oe_d;
            tx_stop_q  <= tx_stop_d;
            ser_tx_q   <= ser_tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_pe_q    <= rx_pe_d;
            rx_oe_q    <= rx_oe_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // TX next state: config is captured at accept so mid-frame input changes are ignored
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_pe_d    = tx_pe_q;
        tx_oe_d    = tx_oe_q;
        tx_stop_d  = tx_stop_q;
        if (CE) begin
            if (tx_state_q == S_IDLE) begin
                if (TX_VALID) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_data_d  = TX_DATA;
                    tx_pe_d    = PE;
                    tx_oe_d    = OE;
                    tx_stop_d  = STOP;
                end
            end else if (tx_cnt_q != CNT_LAST) begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end else begin
                tx_cnt_d = '0;
                case (tx_state_q)
                    S_START:  tx_state_d = S_DATA;
                    S_DATA: begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) tx_state_d = tx_pe_q ? S_PARITY : S_STOP;
                    end
                    S_PARITY: tx_state_d = S_STOP;
                    default: begin
                        // tx_bit_q doubles as the stop-bit index; it wrapped to 0 after DATA
                        if (tx_stop_q && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
                        else begin
                            tx_state_d = S_IDLE;
                            tx_bit_d   = '0;
                        end
                    end
                endcase
            end
        end
    end

    // TX outputs: line level is registered from the next state so SER_TX is glitch-free
    always_comb begin
        TX_READY = (tx_state_q == S_IDLE);
        case (tx_state_d)
            S_START:  ser_tx_d = 1'b0;
            S_DATA:   ser_tx_d = tx_data_d[tx_bit_d];
            S_PARITY: ser_tx_d = (^tx_data_d) ^ tx_oe_d;
            default:  ser_tx_d = 1'b1;
        endcase
    end

    assign SER_TX = ser_tx_q;

    always_comb begin
        sync_d     = CE ? {sync_q[0], SER_RX} : sync_q;
        rx_prev_d  = CE ? rx_s : rx_prev_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_pe_d    = rx_pe_q;
        rx_oe_d    = rx_oe_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = CE ? 1'b0 : rx_valid_q;
        if (CE) begin
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_state_d = S_START;
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_pe_d    = PE;
                        rx_oe_d    = OE;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_d   = '0;
                        rx_state_d = rx_s ? S_IDLE : S_DATA;
                    end else rx_cnt_d = rx_cnt_q + CW'(1);
                end
                default: begin
                    if (rx_cnt_q != CNT_LAST) rx_cnt_d = rx_cnt_q + CW'(1);
                    else begin
                        rx_cnt_d = '0;
                        case (rx_state_q)
                            S_DATA: begin
                                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                                rx_bit_d   = rx_bit_q + 3'd1;
                                if (rx_bit_q == 3'd7) rx_state_d = rx_pe_q ? S_PARITY : S_STOP;
                            end
                            S_PARITY: begin
                                rx_par_d   = rx_s != ((^rx_shift_q) ^ rx_oe_q);
                                rx_state_d = S_STOP;
                            end
                            default: begin
                                // Back to IDLE at mid-stop so a start edge in the last half bit is seen
                                rx_data_d  = rx_shift_q;
                                rx_perr_d  = rx_pe_q & rx_par_q;
                                rx_ferr_d  = ~rx_s;
                                rx_valid_d = 1'b1;
                                rx_state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign RX_PERR  = rx_perr_q;
    assign RX_FERR  = rx_ferr_q;
endmodule

// File: doc/sci_link_peer.md
SCI_LINK_PEER -- requirements
Module: sci_link_peer

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 32, giving the number of CE-qualified clocks per serial bit; legal values are even and >= 4.
REQ-002 The block SHALL have input CLK, 1 bit: system clock.
REQ-003 The block SHALL have input RST_N, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have input CE, 1 bit: clock enable; all state advances only on CLK edges with CE=1.
REQ-005 The block SHALL have inputs PE, OE and STOP, 1 bit each: parity enable, odd parity, and two stop bits (TX only).
REQ-006 The block SHALL have inputs TX_DATA [7:0] and TX_VALID, 1 bit: byte to transmit and its request.
REQ-007 The block SHALL have output TX_READY, 1 bit: transmitter idle, able to accept a byte.
REQ-008 The block SHALL have output SER_TX, 1 bit: serial line toward the SCI RXD pin, idle high.
REQ-009 The block SHALL have input SER_RX, 1 bit: serial line from the SCI TXD pin, asynchronous.
REQ-010 The block SHALL have outputs RX_DATA [7:0], RX_VALID, RX_PERR and RX_FERR: received byte, one-CE-cycle strobe, parity error and framing error.

Function
REQ-011 Frame format SHALL be: start bit (0), 8 data bits LSB first, an optional parity bit, then stop bit(s) (1).
REQ-012 The parity bit SHALL be XOR(data) when OE=0 and ~XOR(data) when OE=1.
REQ-013 The TX FSM SHALL have states IDLE, START, DATA, PARITY and STOP; TX_READY=1 only in IDLE.
REQ-014 Accept SHALL occur on a CE cycle with TX_VALID=1 in IDLE: TX_DATA, PE, OE and STOP are latched, SER_TX becomes 0 from the next clock, and the FSM enters START.
REQ-015 Each TX bit SHALL be held for exactly BIT_CYCLES CE cycles; a 3-bit counter indexes data bits 0..7.
REQ-016 TX transitions SHALL be: DATA->PARITY if PE=1, else DATA->STOP; STOP lasts 1 or 2 bit times per STOP.
REQ-017 At the end of STOP, the TX FSM SHALL go to IDLE and TX_READY=1, so the next accept is possible in that same cycle.
REQ-018 TX_VALID while not in IDLE SHALL be ignored; changes to config inputs mid-frame SHALL have no effect.
REQ-019 SER_RX SHALL pass through a 2-flop synchronizer; RX SHALL use only the synchronized value.
REQ-020 The RX FSM SHALL have states IDLE, START, DATA, PARITY and STOP; a high->low transition in IDLE SHALL enter START and clear the bit-time counter.
REQ-021 At count BIT_CYCLES/2 in START, the line SHALL be sampled: if high (glitch), RX SHALL return to IDLE with no strobe; if low, RX enters DATA.
REQ-022 Subsequent samples SHALL be taken every BIT_CYCLES CE cycles (mid-bit), shifting into RX_DATA LSB first.
REQ-023 RX_PERR SHALL equal (sampled parity != expected parity) when PE=1, and 0 when PE=0.
REQ-024 Only the first stop bit SHALL be checked, with RX_FERR = ~sample.
REQ-025 At the first-stop-bit sample, RX SHALL update RX_DATA, RX_PERR and RX_FERR, pulse RX_VALID for exactly 1 CE cycle, and return to IDLE immediately, so a start edge in the remaining half bit is accepted.
REQ-026 RX_DATA, RX_PERR and RX_FERR SHALL hold until the next strobe; there is no backpressure, so an unread byte is overwritten.
REQ-027 TX and RX SHALL be fully independent, allowing full duplex.

Reset
REQ-028 RST_N=0 SHALL force asynchronously: SER_TX=1, TX_READY=1, RX_VALID=0, RX_DATA=0x00, RX_PERR=0, RX_FERR=0, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-029 Reset mid-frame SHALL abort the frame with no partial strobe; after release, the line stays idle until a new accept.

Verification
REQ-030 BIT_CYCLES=4, CE=1, PE=0, STOP=0, TX 0xA5 -> SER_TX = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; TX_READY low for 40 clocks.
REQ-031 TX 0x03 with PE=1, OE=0, STOP=1 -> parity bit 0, two stop bits, 48 clocks; repeat with OE=1 -> parity bit 1.
REQ-032 Loopback SER_TX->SER_RX, back-to-back 0x5A then 0xFF -> two RX_VALID pulses, RX_DATA 0x5A then 0xFF, RX_PERR=0 and RX_FERR=0 both times.
REQ-033 SER_RX low for 1 clock only -> no RX_VALID, and RX is back in IDLE by the mid-start sample.
REQ-034 Driven frame 0x00 with stop bit 0 -> RX_VALID with RX_FERR=1; frame with PE=1 and a wrong parity bit -> RX_PERR=1.
REQ-035 RST_N low during TX data bit 3 -> SER_TX=1 and TX_READY=1 immediately; after release, 100 clocks of SER_TX=1 with no RX_VALID.
